// File: rtl/shift_pkg.sv
// Shared types for the sequential shift unit.
// Step opcodes, FSM states and default datapath sizes.
package shift_pkg;

    localparam int SH_W  = 16;
    localparam int SH_AW = 4;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shifter.sv
// Combinational one-bit shifter used as the step datapath.
// ASR refills the top bit from the current sign bit.
module shifter
    import shift_pkg::*;
#(
    parameter int W = SH_W
) (
    input  logic [W-1:0] in,
    input  shift_op_t    shift,
    output logic [W-1:0] sout
);

    always_comb begin
        sout = in;
        case (shift)
            SH_LSL:  sout = {in[W-2:0], 1'b0};
            SH_LSR:  sout = {1'b0, in[W-1:1]};
            SH_ASR:  sout = {in[W-1], in[W-1:1]};
            default: sout = in;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift-by-N unit with a start/done handshake.
// Define SHIFT_SEQ_FAST2_EN to retire two steps per cycle.
module shift_seq
    import shift_pkg::*;
#(
    parameter int W  = SH_W,
    parameter int AW = SH_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  in,
    input  logic [1:0]    op,
    input  logic [AW-1:0] amt,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  sout,
    output logic          cout
);

    state_t        state;
    shift_op_t     op_q;
    logic [AW-1:0] cnt;
    logic [W-1:0]  step1;

    // Bit leaving the word when v is shifted one place by o.
    function automatic logic out_bit(
        input logic [W-1:0] v,
        input shift_op_t    o
    );
        return (o == SH_LSL) ? v[W-1] : v[0];
    endfunction

    shifter #(.W(W)) u_step0 (
        .in    (sout),
        .shift (op_q),
        .sout  (step1)
    );

`ifdef SHIFT_SEQ_FAST2_EN
    logic [W-1:0] step2;

    shifter #(.W(W)) u_step1 (
        .in    (step1),
        .shift (op_q),
        .sout  (step2)
    );
`endif

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= SH_NONE;
            cnt   <= '0;
            sout  <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sout  <= in;
                        cout  <= 1'b0;
                        op_q  <= shift_op_t'(op);
                        cnt   <= (op == 2'b00) ? '0 : amt;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        state <= DONE;
`ifdef SHIFT_SEQ_FAST2_EN
                    end else if (cnt >= AW'(2)) begin
                        sout <= step2;
                        cout <= out_bit(step1, op_q);
                        cnt  <= cnt - AW'(2);
`endif
                    end else begin
                        sout <= step1;
                        cout <= out_bit(sout, op_q);
                        cnt  <= cnt - AW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq against a behavioural model.
// Honours SHIFT_SEQ_FAST2_EN for expected latency.
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] in;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic        busy;
    logic        done;
    logic [15:0] sout;
    logic        cout;

    int checks = 0;
    int passes = 0;

    shift_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (in),
        .op    (op),
        .amt   (amt),
        .busy  (busy),
        .done  (done),
        .sout  (sout),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    function automatic void model(
        input  logic [15:0] v,
        input  logic [1:0]  o,
        input  logic [3:0]  a,
        output logic [15:0] r,
        output logic        c,
        output int          lat
    );
        int n;
        n = (o == 2'b00) ? 0 : int'(a);
        r = v;
        c = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (o)
                2'b01: begin c = r[15]; r = r << 1; end
                2'b10: begin c = r[0];  r = r >> 1; end
                default: begin
                    c = r[0];
                    r = 16'($signed(r) >>> 1);
                end
            endcase
        end
`ifdef SHIFT_SEQ_FAST2_EN
        lat = (n + 1) / 2 + 1;
`else
        lat = n + 1;
`endif
    endfunction

    task automatic run_op(
        input logic [15:0] v,
        input logic [1:0]  o,
        input logic [3:0]  a,
        input string       tag
    );
        logic [15:0] er;
        logic        ec;
        int          el;
        int          k;
        int          bcnt;
        model(v, o, a, er, ec, el);
        @(negedge clk);
        in = v; op = o; amt = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in = 16'($urandom); op = 2'($urandom); amt = 4'($urandom);
        k = 0;
        bcnt = 0;
        while (!done && k <= 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (!done) begin
            $display("FAIL %s timeout: no done after %0d cycles, required at %0d", tag, k, el);
            return;
        end
        passes++;
        checks++;
        if (k !== el) $display("FAIL %s latency: got %0d required %0d", tag, k, el);
        else passes++;
        checks++;
        if (bcnt !== el) $display("FAIL %s busy_cycles: got %0d required %0d", tag, bcnt, el);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b required 0", tag, busy);
        else passes++;
        checks++;
        if (sout !== er) $display("FAIL %s sout: got %h required %h", tag, sout, er);
        else passes++;
        checks++;
        if (cout !== ec) $display("FAIL %s cout: got %b required %b", tag, cout, ec);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s after_done: got done=%b busy=%b required 0/0", tag, done, busy);
        else passes++;
        checks++;
        if (sout !== er) $display("FAIL %s sout_hold: got %h required %h", tag, sout, er);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; in = 16'hFFFF; op = 2'b01; amt = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
        else passes++;
        checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done);
        else passes++;
        checks++;
        if (sout !== 16'h0) $display("FAIL reset_sout: got %h required 0000", sout);
        else passes++;
        checks++;
        if (cout !== 1'b0) $display("FAIL reset_cout: got %b required 0", cout);
        else passes++;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after_reset: got busy=%b done=%b required 0/0", busy, done);
        else passes++;
    endtask

    task automatic test_plan_vectors();
        run_op(16'hABCD, 2'b01, 4'd4, "lsl4");
        run_op(16'hFF1D, 2'b10, 4'd1, "lsr1");
        run_op(16'h8000, 2'b11, 4'd15, "asr15");
        run_op(16'h1234, 2'b11, 4'd0, "asr0");
        run_op(16'h1234, 2'b00, 4'd7, "none7");
    endtask

    task automatic test_start_while_busy();
        logic [15:0] r;
        logic        c;
        int          el;
        int          pulses;
        int          seen;
        logic [15:0] er;
        logic        ec;
        model(16'h00FF, 2'b01, 4'd8, er, ec, el);
        r = '0; c = 1'b0; pulses = 0; seen = -1;
        @(negedge clk);
        in = 16'h00FF; op = 2'b01; amt = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                pulses++;
                if (seen < 0) begin seen = k; r = sout; c = cout; end
            end
            if (k == 2) begin
                @(negedge clk);
                in = 16'hFFFF; op = 2'b10; amt = 4'd2; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (pulses !== 1) $display("FAIL busy_start pulses: got %0d required 1", pulses);
        else passes++;
        checks++;
        if (seen !== el) $display("FAIL busy_start latency: got %0d required %0d", seen, el);
        else passes++;
        checks++;
        if (r !== 16'hFF00) $display("FAIL busy_start sout: got %h required ff00", r);
        else passes++;
        checks++;
        if (c !== 1'b0) $display("FAIL busy_start cout: got %b required 0", c);
        else passes++;
    endtask

    task automatic test_reset_abort();
        int pulses;
        pulses = 0;
        @(negedge clk);
        in = 16'hFFFF; op = 2'b10; amt = 4'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %b required 0", busy);
        else passes++;
        checks++;
        if (sout !== 16'h0) $display("FAIL abort_sout: got %h required 0000", sout);
        else passes++;
        checks++;
        if (cout !== 1'b0) $display("FAIL abort_cout: got %b required 0", cout);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL abort_done: got %0d pulses required 0", pulses);
        else passes++;
        run_op(16'h0F0F, 2'b10, 4'd4, "after_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 2'($urandom), 4'($urandom), "random");
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    task automatic test_back_to_back();
        run_op(16'h8001, 2'b01, 4'd15, "b2b_lsl15");
        run_op(16'h8001, 2'b10, 4'd15, "b2b_lsr15");
        run_op(16'h4000, 2'b11, 4'd14, "b2b_asr14");
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_start_while_busy();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
